// File: rtl/airlock_sequencer.sv
// Airlock door/pump sequencer driving an external seconds countdown timer.
// Define ABORT_EN to add the abort input (PRESS -> DEPRESS, OUT_CLOSE -> OUT_OPEN).
module airlock_sequencer #(
  parameter int DOOR_SECS    = 300,
  parameter int PRESS_SECS   = 420,
  parameter int DEPRESS_SECS = 480,
  parameter int TW           = 10
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive_req,
  input  logic          depart_req,
`ifdef ABORT_EN
  input  logic          abort,
`endif
  input  logic          timer_done,
  output logic          timer_start,
  output logic [TW-1:0] timer_seconds,
  output logic          outer_door_open,
  output logic          inner_door_open,
  output logic          pressurize,
  output logic          depressurize,
  output logic          busy,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    OUT_OPEN  = 3'd0,
    OUT_CLOSE = 3'd1,
    PRESS     = 3'd2,
    IN_OPEN   = 3'd3,
    IN_CLOSE  = 3'd4,
    DEPRESS   = 3'd5
  } state_t;

  localparam logic [TW-1:0] DOOR_T    = TW'(DOOR_SECS);
  localparam logic [TW-1:0] PRESS_T   = TW'(PRESS_SECS);
  localparam logic [TW-1:0] DEPRESS_T = TW'(DEPRESS_SECS);

  state_t        st_q;
  state_t        st_d;
  logic          start_d;
  logic [TW-1:0] secs_d;
  logic          go;
  logic          ab;

`ifdef ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif

  // timer_done is stale on the cycle the start pulse is out
  assign go = ~timer_start;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q          <= OUT_OPEN;
      timer_start   <= 1'b0;
      timer_seconds <= DOOR_T;
    end else begin
      st_q          <= st_d;
      timer_start   <= start_d;
      timer_seconds <= secs_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    start_d = 1'b0;
    secs_d  = timer_seconds;
    case (st_q)
      OUT_OPEN: begin
        if (go && arrive_req) begin
          st_d    = OUT_CLOSE;
          start_d = 1'b1;
          secs_d  = DOOR_T;
        end
      end
      OUT_CLOSE: begin
        if (go && ab) begin
          st_d = OUT_OPEN;
        end else if (go && timer_done) begin
          st_d    = PRESS;
          start_d = 1'b1;
          secs_d  = PRESS_T;
        end
      end
      PRESS: begin
        if (go && ab) begin
          st_d    = DEPRESS;
          start_d = 1'b1;
          secs_d  = DEPRESS_T;
        end else if (go && timer_done) begin
          st_d = IN_OPEN;
        end
      end
      IN_OPEN: begin
        if (go && depart_req) begin
          st_d    = IN_CLOSE;
          start_d = 1'b1;
          secs_d  = DOOR_T;
        end
      end
      IN_CLOSE: begin
        if (go && timer_done) begin
          st_d    = DEPRESS;
          start_d = 1'b1;
          secs_d  = DEPRESS_T;
        end
      end
      DEPRESS: begin
        if (go && timer_done) begin
          st_d = OUT_OPEN;
        end
      end
      default: st_d = OUT_OPEN;
    endcase
  end

  assign state           = st_q;
  assign outer_door_open = (st_q == OUT_OPEN);
  assign inner_door_open = (st_q == IN_OPEN);
  assign pressurize      = (st_q == PRESS);
  assign depressurize    = (st_q == DEPRESS);
  assign busy            = ~((st_q == OUT_OPEN) |
                             (st_q == IN_OPEN));

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: vector table plus hand sequences,
// each instance paired with a behavioural countdown timer.
module tb_airlock_sequencer;

  typedef struct packed {
    logic       start;
    logic [9:0] secs;
    logic       od;
    logic       id;
    logic       pr;
    logic       dp;
    logic       busy;
    logic [2:0] st;
  } obs_t;

  typedef struct {
    bit rst;
    bit arr;
    bit dep;
    int n;
    int st;
    bit start;
    int secs;
  } vec_t;

  logic clk;
  logic reset;
  logic arr_a, dep_a, arr_b, arr_c;

  logic       ts_a, od_a, id_a, pr_a, dp_a, bz_a;
  logic [9:0] sc_a;
  logic [2:0] st_a;
  logic       ts_b, od_b, id_b, pr_b, dp_b, bz_b;
  logic [9:0] sc_b;
  logic [2:0] st_b;
  logic       ts_c, od_c, id_c, pr_c, dp_c, bz_c;
  logic [9:0] sc_c;
  logic [2:0] st_c;

  logic [9:0] cnt_a, cnt_b, cnt_c;
  logic       dn_a, dn_b, dn_c;

`ifdef ABORT_EN
  logic ab_a, ab_b, ab_c;
`endif

  obs_t oa, ob, oc;
  obs_t sbq[$];
  vec_t tbl[$];
  int   total;
  int   bad;

  airlock_sequencer #(
    .DOOR_SECS(2), .PRESS_SECS(3),
    .DEPRESS_SECS(4), .TW(10)
  ) u_a (
    .clk(clk), .reset(reset),
    .arrive_req(arr_a), .depart_req(dep_a),
`ifdef ABORT_EN
    .abort(ab_a),
`endif
    .timer_done(dn_a), .timer_start(ts_a),
    .timer_seconds(sc_a),
    .outer_door_open(od_a), .inner_door_open(id_a),
    .pressurize(pr_a), .depressurize(dp_a),
    .busy(bz_a), .state(st_a)
  );

  airlock_sequencer u_b (
    .clk(clk), .reset(reset),
    .arrive_req(arr_b), .depart_req(1'b0),
`ifdef ABORT_EN
    .abort(ab_b),
`endif
    .timer_done(dn_b), .timer_start(ts_b),
    .timer_seconds(sc_b),
    .outer_door_open(od_b), .inner_door_open(id_b),
    .pressurize(pr_b), .depressurize(dp_b),
    .busy(bz_b), .state(st_b)
  );

  airlock_sequencer #(
    .DOOR_SECS(0), .PRESS_SECS(3),
    .DEPRESS_SECS(4), .TW(10)
  ) u_c (
    .clk(clk), .reset(reset),
    .arrive_req(arr_c), .depart_req(1'b0),
`ifdef ABORT_EN
    .abort(ab_c),
`endif
    .timer_done(dn_c), .timer_start(ts_c),
    .timer_seconds(sc_c),
    .outer_door_open(od_c), .inner_door_open(id_c),
    .pressurize(pr_c), .depressurize(dp_c),
    .busy(bz_c), .state(st_c)
  );

  assign oa = {ts_a, sc_a, od_a, id_a, pr_a, dp_a, bz_a, st_a};
  assign ob = {ts_b, sc_b, od_b, id_b, pr_b, dp_b, bz_b, st_b};
  assign oc = {ts_c, sc_c, od_c, id_c, pr_c, dp_c, bz_c, st_c};

  // external countdown timers: load on start, count to zero
  always @(posedge clk) begin
    if (!reset) cnt_a <= '0;
    else if (ts_a) cnt_a <= sc_a;
    else if (cnt_a != 0) cnt_a <= cnt_a - 1'b1;
    if (!reset) cnt_b <= '0;
    else if (ts_b) cnt_b <= sc_b;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1'b1;
    if (!reset) cnt_c <= '0;
    else if (ts_c) cnt_c <= sc_c;
    else if (cnt_c != 0) cnt_c <= cnt_c - 1'b1;
  end

  assign dn_a = (cnt_a == 0);
  assign dn_b = (cnt_b == 0);
  assign dn_c = (cnt_c == 0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(int st, bit start, int secs);
    obs_t o;
    o.st    = st[2:0];
    o.start = start;
    o.secs  = secs[9:0];
    o.od    = (st == 0);
    o.id    = (st == 3);
    o.pr    = (st == 2);
    o.dp    = (st == 5);
    o.busy  = !((st == 0) || (st == 3));
    return o;
  endfunction

  task automatic add(bit r, bit a, bit d, int n,
                     int st, bit s, int secs);
    vec_t v;
    v.rst = r; v.arr = a; v.dep = d; v.n = n;
    v.st = st; v.start = s; v.secs = secs;
    tbl.push_back(v);
  endtask

  task automatic check(string name, obs_t act);
    obs_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected entry", name);
    end else begin
      e = sbq.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got st=%0d start=%0b secs=%0d outs=%b want st=%0d start=%0b secs=%0d outs=%b",
                 name, act.st, act.start, act.secs,
                 {act.od, act.id, act.pr, act.dp, act.busy},
                 e.st, e.start, e.secs,
                 {e.od, e.id, e.pr, e.dp, e.busy});
      end
    end
  endtask

  initial begin
    int cst[9];
    bit cs[9];
    int csec[9];
    total = 0;
    bad   = 0;
    reset = 1'b0;
    arr_a = 0; dep_a = 0; arr_b = 0; arr_c = 0;
`ifdef ABORT_EN
    ab_a = 0; ab_b = 0; ab_c = 0;
`endif

    // reset values on a default-parameter instance
    sbq.push_back(mk(0, 0, 300));
    @(posedge clk); #1;
    check("reset_default", ob);
    reset = 1'b1;

    add(1, 0, 0, 1, 0, 0, 2);
    add(0, 0, 1, 3, 0, 0, 2);
    add(0, 1, 1, 1, 1, 1, 2);
    add(0, 0, 0, 3, 1, 0, 2);
    add(0, 0, 0, 1, 2, 1, 3);
    add(0, 1, 0, 2, 2, 0, 3);
    add(0, 0, 0, 2, 2, 0, 3);
    add(0, 1, 0, 2, 3, 0, 3);
    add(0, 1, 1, 1, 4, 1, 2);
    add(0, 0, 0, 3, 4, 0, 2);
    add(0, 0, 0, 1, 5, 1, 4);
    add(0, 0, 0, 5, 5, 0, 4);
    add(0, 0, 0, 2, 0, 0, 4);
    add(0, 1, 0, 1, 1, 1, 2);
    add(0, 0, 0, 3, 1, 0, 2);
    add(0, 0, 0, 1, 2, 1, 3);
    add(0, 0, 0, 2, 2, 0, 3);
    add(1, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 2, 0, 0, 2);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        reset = !tbl[i].rst;
        arr_a = tbl[i].arr;
        dep_a = tbl[i].dep;
        sbq.push_back(mk(tbl[i].st, tbl[i].start, tbl[i].secs));
        @(posedge clk); #1;
        check($sformatf("vec%0d.%0d", i, k), oa);
      end
    end
    reset = 1'b1;
    arr_a = 0;
    dep_a = 0;

    // zero-length door phase: stale done must not skip PRESS
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cst  = '{1, 1, 2, 2, 2, 2, 2, 3, 3};
    cs   = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    csec = '{0, 0, 3, 3, 3, 3, 3, 3, 3};
    for (int k = 0; k < 9; k++) begin
      arr_c = (k == 0);
      sbq.push_back(mk(cst[k], cs[k], csec[k]));
      @(posedge clk); #1;
      check($sformatf("stale%0d", k), oc);
    end
    arr_c = 0;

`ifdef ABORT_EN
    begin
      int waited;
      arr_b = 1;
      @(posedge clk); #1;
      arr_b = 0;
      waited = 0;
      while (!(st_b == 3'd2 && ts_b == 1'b0) && waited < 400) begin
        @(posedge clk); #1;
        waited++;
      end
      if (waited >= 400) begin
        total++;
        bad++;
        $display("FAIL abort_wait: st=%0d never reached PRESS", st_b);
      end else begin
        ab_b = 1;
        sbq.push_back(mk(5, 1, 480));
        @(posedge clk); #1;
        ab_b = 0;
        check("abort_press", ob);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
